// File: rtl/str_check_ctrl.sv
// str_check_ctrl: sequencer between the byte receiver and the string recognizer.
// Bytes are buffered in a small FIFO and strings are framed by 0x00 delimiters.
// Each fed byte is followed by a settle cycle, so the recognizer's registered
// state is valid before the next byte or the verdict is taken.
// Optional build macro STR_CHECK_CTRL_LEN_LIMIT_EN limits the payload length to MAX_LEN.
module str_check_ctrl #(
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 1000,
  parameter int WAIT_MAX = 4,
  parameter int CNT_W    = 8,
  parameter int MAX_LEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [3:0]       fsm_state,
  output logic [7:0]       char_out,
  output logic             char_valid,
  output logic             verify_error,
  output logic             res_valid,
  output logic             res_ok,
  output logic             res_timeout,
  input  logic             res_ready,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err,
  output logic             overflow,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {C_IDLE, C_SETTLE, C_FEED, C_WAIT, C_REPORT, C_DRAIN} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] wait_cnt;
  logic          abort_reg;
  logic          drain_reg;
  logic          len_hit;
  logic          fin;
  logic          fin_ok;
  logic          fin_to;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Held low during reset so every output reads 0 while rst is asserted.
  assign rx_ready = rst && !full;
  assign push     = rx_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign busy     = (state != C_IDLE);

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef STR_CHECK_CTRL_LEN_LIMIT_EN
  localparam int LW = $clog2(MAX_LEN + 2);
  logic [LW-1:0] len_cnt;
  assign len_hit = (head != 8'h00) && (len_cnt == LW'(MAX_LEN));

  // Payload length counter, restarted at every opening delimiter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_cnt <= '0;
    end else if (state == C_IDLE) begin
      len_cnt <= '0;
    end else if (state == C_FEED && pop && head != 8'h00 && !len_hit) begin
      len_cnt <= len_cnt + 1'b1;
    end
  end
`else
  assign len_hit = 1'b0;
`endif

  // Pop whenever the controller is in a byte-consuming state and data is present
  always_comb begin
    pop = 1'b0;
    case (state)
      C_IDLE, C_FEED, C_DRAIN: pop = !empty;
      default:                 pop = 1'b0;
    endcase
  end

  // Verdict decision: a timeout-class failure always pulses verify_error
  always_comb begin
    fin    = 1'b0;
    fin_ok = 1'b0;
    fin_to = 1'b0;
    case (state)
      C_FEED: begin
        if (pop) begin
          if (abort_reg || len_hit) begin
            fin    = 1'b1;
            fin_to = 1'b1;
          end
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          fin    = 1'b1;
          fin_to = 1'b1;
        end
      end
      C_WAIT: begin
        if (fsm_state == 4'd2) begin
          fin    = 1'b1;
          fin_ok = 1'b1;
        end else if (fsm_state == 4'd0) begin
          fin    = 1'b1;
        end else if (wait_cnt == WW'(WAIT_MAX - 1)) begin
          fin    = 1'b1;
          fin_to = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with registered strobes, result and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= C_IDLE;
      char_out     <= 8'h00;
      char_valid   <= 1'b0;
      verify_error <= 1'b0;
      res_valid    <= 1'b0;
      res_ok       <= 1'b0;
      res_timeout  <= 1'b0;
      cnt_ok       <= '0;
      cnt_err      <= '0;
      overflow     <= 1'b0;
      abort_reg    <= 1'b0;
      drain_reg    <= 1'b0;
      tmo_cnt      <= '0;
      wait_cnt     <= '0;
    end else begin
      char_valid   <= 1'b0;
      verify_error <= 1'b0;
      if (fin) begin
        res_valid    <= 1'b1;
        res_ok       <= fin_ok;
        res_timeout  <= fin_to;
        verify_error <= fin_to;
        if (fin_ok) cnt_ok  <= (&cnt_ok)  ? cnt_ok  : cnt_ok  + 1'b1;
        else        cnt_err <= (&cnt_err) ? cnt_err : cnt_err + 1'b1;
        // An abort mid-payload leaves the rest of that string to be drained
        drain_reg    <= (state == C_FEED) && pop && (head != 8'h00);
        if (state == C_FEED) abort_reg <= 1'b0;
        state        <= C_REPORT;
      end else begin
        case (state)
          C_IDLE: begin
            // Only an opening delimiter starts a string; the opening byte also gets a settle cycle
            if (pop && head == 8'h00) begin
              char_out   <= head;
              char_valid <= 1'b1;
              tmo_cnt    <= '0;
              state      <= C_SETTLE;
            end
          end
          C_SETTLE: state <= C_FEED;
          C_FEED: begin
            if (pop) begin
              tmo_cnt    <= '0;
              char_out   <= head;
              char_valid <= 1'b1;
              wait_cnt   <= '0;
              state      <= (head == 8'h00) ? C_WAIT : C_SETTLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          C_WAIT: wait_cnt <= wait_cnt + 1'b1;
          C_REPORT: begin
            if (res_ready) begin
              res_valid   <= 1'b0;
              res_ok      <= 1'b0;
              res_timeout <= 1'b0;
              state       <= drain_reg ? C_DRAIN : C_IDLE;
            end
          end
          C_DRAIN: begin
            if (pop && head == 8'h00) begin
              drain_reg <= 1'b0;
              state     <= C_IDLE;
            end
          end
          default: state <= C_IDLE;
        endcase
      end
      // A dropped byte poisons whichever string is fed next
      if (rx_valid && full) begin
        overflow  <= 1'b1;
        abort_reg <= 1'b1;
      end
    end
  end

endmodule

// File: doc/str_check_ctrl.md
Name: str_check_ctrl

Overview:
- Sequencer between the byte receiver and the string-recognition FSM (`tsk`).
- Buffers incoming bytes in a small FIFO and frames strings by 0x00 delimiters.
- Feeds bytes to the recognizer one at a time, paced to its registered `next_state` feedback, and turns the recognizer state into a per-string pass/fail result.
- Aborts stalled strings via `verify_error` and keeps saturating pass/fail counters.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, minimum 2.
- TIMEOUT, 1000: cycles of empty FIFO inside an open string before abort.
- WAIT_MAX, 4: cycles allowed for a verdict after the closing 0x00.
- CNT_W, 8: width of the result counters.
- MAX_LEN, 32: maximum payload bytes per string; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- rx_data  in  8  byte from the receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  FIFO can accept; equals !full.
- fsm_state  in  4  recognizer state (0 IDLE, 1 START, 2 STOP, 3 ERROR, ≥4 variant states).
- char_out  out  8  byte to the classifier/recognizer.
- char_valid  out  1  one-cycle strobe; drives recognizer `valid`.
- verify_error  out  1  one-cycle abort strobe to the recognizer.
- res_valid  out  1  result available; held until accepted.
- res_ok  out  1  1 = string accepted.
- res_timeout  out  1  1 = failure caused by timeout, overflow or length abort.
- res_ready  in  1  result consumer handshake.
- cnt_ok  out  CNT_W  saturating count of accepted strings.
- cnt_err  out  CNT_W  saturating count of rejected strings.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- busy  out  1  controller is not in C_IDLE.

Behaviour:
- Reset (async, rst=0):
  - All outputs 0; FIFO empty; counters 0; controller state C_IDLE.
  - Reset mid-string discards everything; no result is produced.
- FIFO:
  - Push on rx_valid && rx_ready.
  - rx_valid while full: byte dropped, overflow set (sticky), current string marked aborted.
  - Simultaneous push and pop when full is not allowed, because rx_ready=0 when full.
- Controller states:
  - C_IDLE: pop bytes.
    - Non-zero bytes are discarded, no strobe.
    - 0x00 is fed (char_valid=1) and moves to C_FEED.
    - Pops are stalled while res_valid && !res_ready.
  - C_FEED: each pop drives char_out and a char_valid pulse, then goes to C_SETTLE.
    - A popped 0x00 closes the string and moves to C_WAIT.
    - FIFO empty for TIMEOUT consecutive cycles: pulse verify_error, fail with timeout, go to C_REPORT.
  - C_SETTLE: exactly 1 cycle with no strobe, so the recognizer's registered state is visible; then back to C_FEED.
    - Consequence: maximum feed rate is one byte per 2 cycles.
  - C_WAIT (at most WAIT_MAX cycles):
    - fsm_state==2 → ok.
    - fsm_state==0 without a prior 2 → fail.
    - fsm_state==3 → keep waiting.
    - Expiry → pulse verify_error, fail with timeout.
  - C_REPORT:
    - Assert res_valid with res_ok and res_timeout.
    - Increment the matching counter in the same cycle res_valid rises; counters saturate at all-ones.
    - Hold res_valid until res_ready is sampled 1; then C_IDLE.
    - The FIFO keeps accepting bytes during report.
- Overflow abort is handled like a timeout:
  - The next popped byte ends the string: verify_error pulse, fail with timeout.
  - Then the controller drains bytes up to and including the next 0x00 before returning to C_IDLE.
- Consecutive strings: a closing 0x00 never doubles as the next opening 0x00; each string needs its own leading 0x00.
- verify_error and char_valid are never high in the same cycle.

Optional Feature:
- Macro: STR_CHECK_CTRL_LEN_LIMIT_EN.
- Defined:
  - A payload length counter tracks bytes between the delimiters.
  - Feeding byte number MAX_LEN+1 without 0x00 instead pulses verify_error, fails with timeout, and drains to the next 0x00.
- Undefined: no length counter; MAX_LEN is ignored; string length is unbounded.

Test Plan:
- Accepted string: push 0x00,'$','1',0x00 with a recognizer model that accepts → char_valid pulses 2 cycles apart; res_valid with res_ok=1, res_timeout=0; cnt_ok=1.
- Rejected string: push 0x00,'a',0x00 with the model going to ERROR → res_ok=0, res_timeout=0, cnt_err=1; no verify_error pulse.
- Timeout: TIMEOUT=16, push 0x00,'$' then idle 16 cycles → one verify_error pulse, res_ok=0, res_timeout=1.
- Overflow: DEPTH=4, res_ready=0 holding a result, push 6 bytes → rx_ready=0 after 4; overflow=1 sticky; next string fails with timeout.
- Backpressure: res_ready low for 10 cycles → res_valid held stable and no char_valid pulses; accepted on res_ready=1; cnt_ok increments once only.
- Saturation and async reset: CNT_W=2, 5 accepted strings → cnt_ok=3. Drop rst mid-string, with no clk edge → outputs 0 immediately; the next string behaves normally.
